// File: rtl/hpdl_scan_ctrl_if.sv
// Host-side and buffer-side signal bundle for the HPDL-1414 scan controller.
// The slave modport is the controller; the master modport is whatever surrounds it.
interface hpdl_scan_ctrl_if;
    logic       i_wr_valid;
    logic [7:0] i_wr_data;
    logic       o_wr_ready;
    logic       o_mem_we;
    logic [3:0] o_mem_waddr;
    logic [7:0] o_mem_wdata;
    logic       o_mem_re;
    logic [3:0] o_mem_raddr;
    logic [7:0] i_mem_rdata;
    logic       o_caret_strobe;
    logic [6:0] o_hpdl_d;
    logic [1:0] o_hpdl_a;
    logic [3:0] o_hpdl_wr_n;
    logic       o_busy;

    modport slave (
        input  i_wr_valid, i_wr_data, i_mem_rdata,
        output o_wr_ready, o_mem_we, o_mem_waddr, o_mem_wdata, o_mem_re, o_mem_raddr,
               o_caret_strobe, o_hpdl_d, o_hpdl_a, o_hpdl_wr_n, o_busy
    );

    modport master (
        output i_wr_valid, i_wr_data, i_mem_rdata,
        input  o_wr_ready, o_mem_we, o_mem_waddr, o_mem_wdata, o_mem_re, o_mem_raddr,
               o_caret_strobe, o_hpdl_d, o_hpdl_a, o_hpdl_wr_n, o_busy
    );
endinterface

// File: rtl/hpdl_scan_ctrl.sv
// Display-buffer controller for four HPDL-1414 displays: host write cursor, caret
// blink, and a periodic scanner that replays the 16-char buffer onto the HPDL bus.
module hpdl_scan_ctrl #(
    parameter int unsigned SETUP_CYC   = 2,
    parameter int unsigned PULSE_CYC   = 4,
    parameter int unsigned HOLD_CYC    = 2,
    parameter int unsigned REFRESH_DIV = 12000,
    parameter int unsigned BLINK_DIV   = 6000000
) (
    input  logic              i_clk,
    input  logic              i_reset,
    hpdl_scan_ctrl_if.slave   bus
);
    localparam int unsigned PH_MAX = (SETUP_CYC > PULSE_CYC)
                                   ? ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC)
                                   : ((PULSE_CYC > HOLD_CYC) ? PULSE_CYC : HOLD_CYC);
    localparam int unsigned TW = (PH_MAX > 1)      ? $clog2(PH_MAX)      : 1;
    localparam int unsigned RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned BW = (BLINK_DIV > 1)   ? $clog2(BLINK_DIV)   : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_LATCH, S_SETUP, S_PULSE, S_HOLD, S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    idx_q, idx_d;
    logic [TW-1:0] ph_q, ph_d;
    logic [RW-1:0] ref_q, ref_d;
    logic          pend_q, pend_d;
    logic [BW-1:0] blink_q, blink_d;
    logic          caret_q, caret_d;
    logic [3:0]    cursor_q, cursor_d;
    logic          we_q, we_d;
    logic          defer_q, defer_d;
    logic [7:0]    wdata_q, wdata_d;
    logic          re_q, re_d;
    logic [3:0]    raddr_q, raddr_d;
    logic [6:0]    hd_q, hd_d;
    logic [1:0]    ha_q, ha_d;
    logic [3:0]    wrn_q, wrn_d;
    logic          busy_q, busy_d;
    logic          ready_q, ready_d;

    logic          accept, is_cr, is_bs, is_wr, wr_go, ref_wrap, blink_wrap;
    logic [7:0]    wchar;
    logic [3:0]    cur_base;
    logic          unused_rdata_msb;

    assign unused_rdata_msb = bus.i_mem_rdata[7];

    // Host character classification
    assign accept = bus.i_wr_valid && ready_q;
    assign is_cr  = (bus.i_wr_data == 8'h0D);
    assign is_bs  = (bus.i_wr_data == 8'h08);
    assign is_wr  = (bus.i_wr_data >= 8'h20) && (bus.i_wr_data < 8'h7B);
    assign wr_go  = accept && is_wr;
    assign wchar  = (bus.i_wr_data >= 8'h61) ? (bus.i_wr_data - 8'h20)
                  : (bus.i_wr_data == 8'h60) ? 8'h20 : bus.i_wr_data;

    assign ref_wrap   = (ref_q == RW'(REFRESH_DIV - 1));
    assign blink_wrap = (blink_q == BW'(BLINK_DIV - 1));

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        ph_d     = ph_q;
        pend_d   = pend_q;
        hd_d     = hd_q;
        ha_d     = ha_q;
        busy_d   = busy_q;
        ref_d    = ref_wrap ? '0 : ref_q + RW'(1);
        blink_d  = blink_wrap ? '0 : blink_q + BW'(1);
        caret_d  = blink_wrap ? ~caret_q : caret_q;

        case (state_q)
            S_IDLE: begin
                if (pend_q && !wr_go) begin
                    pend_d  = 1'b0;
                    idx_d   = 4'd0;
                    busy_d  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: state_d = S_LATCH;
            S_LATCH: begin
                hd_d    = bus.i_mem_rdata[6:0];
                ha_d    = 2'd3 - idx_q[1:0];
                ph_d    = '0;
                state_d = S_SETUP;
            end
            S_SETUP: begin
                ph_d = ph_q + TW'(1);
                if (ph_q == TW'(SETUP_CYC - 1)) begin
                    ph_d    = '0;
                    state_d = S_PULSE;
                end
            end
            S_PULSE: begin
                ph_d = ph_q + TW'(1);
                if (ph_q == TW'(PULSE_CYC - 1)) begin
                    ph_d    = '0;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                ph_d = ph_q + TW'(1);
                if (ph_q == TW'(HOLD_CYC - 1)) begin
                    ph_d = '0;
                    if (idx_q == 4'd15) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        state_d = S_FETCH;
                    end
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // A wrap always wins over the IDLE clear so no request is ever lost.
        if (ref_wrap) pend_d = 1'b1;

        re_d    = (state_d == S_FETCH);
        raddr_d = re_d ? idx_d : raddr_q;
        ready_d = (state_d != S_FETCH);
        wrn_d   = (state_d == S_PULSE) ? ~(4'b0001 << idx_d[3:2]) : 4'hF;

        // A char accepted just before FETCH is parked one cycle so we/re never overlap.
        we_d    = defer_q;
        defer_d = 1'b0;
        wdata_d = wdata_q;
        if (wr_go) begin
            wdata_d = wchar;
            if (state_d == S_FETCH) defer_d = 1'b1;
            else                    we_d    = 1'b1;
        end

        // Cursor advances after the write pulse; CR/BS then apply on top in arrival order.
        cur_base = (we_q && cursor_q != 4'd15) ? cursor_q + 4'd1 : cursor_q;
        cursor_d = cur_base;
        if (accept && is_cr)      cursor_d = 4'd0;
        else if (accept && is_bs) cursor_d = (cur_base == 4'd0) ? 4'd0 : cur_base - 4'd1;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q  <= S_IDLE;
            idx_q    <= 4'd0;
            ph_q     <= '0;
            ref_q    <= '0;
            pend_q   <= 1'b0;
            blink_q  <= '0;
            caret_q  <= 1'b1;
            cursor_q <= 4'd0;
            we_q     <= 1'b0;
            defer_q  <= 1'b0;
            wdata_q  <= 8'd0;
            re_q     <= 1'b0;
            raddr_q  <= 4'd0;
            hd_q     <= 7'd0;
            ha_q     <= 2'd0;
            wrn_q    <= 4'hF;
            busy_q   <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            ph_q     <= ph_d;
            ref_q    <= ref_d;
            pend_q   <= pend_d;
            blink_q  <= blink_d;
            caret_q  <= caret_d;
            cursor_q <= cursor_d;
            we_q     <= we_d;
            defer_q  <= defer_d;
            wdata_q  <= wdata_d;
            re_q     <= re_d;
            raddr_q  <= raddr_d;
            hd_q     <= hd_d;
            ha_q     <= ha_d;
            wrn_q    <= wrn_d;
            busy_q   <= busy_d;
            ready_q  <= ready_d;
        end
    end

    assign bus.o_wr_ready     = ready_q;
    assign bus.o_mem_we       = we_q;
    assign bus.o_mem_waddr    = cursor_q;
    assign bus.o_mem_wdata    = wdata_q;
    assign bus.o_mem_re       = re_q;
    assign bus.o_mem_raddr    = raddr_q;
    assign bus.o_caret_strobe = caret_q;
    assign bus.o_hpdl_d       = hd_q;
    assign bus.o_hpdl_a       = ha_q;
    assign bus.o_hpdl_wr_n    = wrn_q;
    assign bus.o_busy         = busy_q;
endmodule

// File: tb/tb_hpdl_scan_ctrl.sv
// Scoreboard bench for hpdl_scan_ctrl: a 16-byte buffer model answers reads, host chars
// are predicted from the character rules, and a monitor checks writes and HPDL digits.
`timescale 1ns/1ps
module tb_hpdl_scan_ctrl;
    localparam int unsigned SETUP_CYC   = 2;
    localparam int unsigned PULSE_CYC   = 4;
    localparam int unsigned HOLD_CYC    = 2;
    localparam int unsigned REFRESH_DIV = 100;
    localparam int unsigned BLINK_DIV   = 4;
    localparam int unsigned CHAR_CYC    = 2 + SETUP_CYC + PULSE_CYC + HOLD_CYC;
    localparam int unsigned FRAME_CYC   = 16 * CHAR_CYC + 2;

    typedef struct packed { logic [3:0] a; logic [7:0] d; } wr_t;
    typedef struct packed { logic [6:0] d; logic [1:0] a; logic [3:0] wrn; } disp_t;

    logic i_clk = 1'b0;
    logic i_reset;
    always #5 i_clk = ~i_clk;

    hpdl_scan_ctrl_if bus();

    hpdl_scan_ctrl #(
        .SETUP_CYC(SETUP_CYC), .PULSE_CYC(PULSE_CYC), .HOLD_CYC(HOLD_CYC),
        .REFRESH_DIV(REFRESH_DIV), .BLINK_DIV(BLINK_DIV)
    ) dut (
        .i_clk  (i_clk),
        .i_reset(i_reset),
        .bus    (bus)
    );

    // Display buffer: synchronous write, one-clock read latency.
    logic [7:0] mem [16];
    always @(posedge i_clk) begin
        if (bus.o_mem_we) mem[bus.o_mem_waddr] <= bus.o_mem_wdata;
        if (bus.o_mem_re) bus.i_mem_rdata <= mem[bus.o_mem_raddr];
    end

    wr_t        exp_wr[$];
    disp_t      exp_disp[$];
    logic [7:0] model_buf [16];
    int         model_cur;
    int         n_chk  = 0;
    int         n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference behaviour of one accepted host character.
    task automatic model_accept(input logic [7:0] c);
        logic [7:0] w;
        if (c == 8'h0D) model_cur = 0;
        else if (c == 8'h08) model_cur = (model_cur > 0) ? model_cur - 1 : 0;
        else if (c >= 8'h20 && c < 8'h7B) begin
            if (c >= 8'h61)      w = c - 8'h20;
            else if (c == 8'h60) w = 8'h20;
            else                 w = c;
            exp_wr.push_back('{a: 4'(model_cur), d: w});
            model_buf[model_cur] = w;
            if (model_cur < 15) model_cur++;
        end
    endtask

    task automatic send(input logic [7:0] c);
        int tries = 0;
        bus.i_wr_valid = 1'b1;
        bus.i_wr_data  = c;
        while (!bus.o_wr_ready && tries < 20) begin
            @(negedge i_clk);
            tries++;
        end
        check("accept_wait", 32'((tries > 1) ? tries : 0), 32'd0);
        if (bus.o_wr_ready) begin
            model_accept(c);
            @(negedge i_clk);
        end
        bus.i_wr_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge i_clk);
    endtask

    task automatic wait_rise(output int cyc, output int hi, output bit found);
        logic prev;
        prev  = bus.o_busy;
        cyc   = 0;
        hi    = 0;
        found = 0;
        while (!found && cyc < 1000) begin
            @(negedge i_clk);
            cyc++;
            if (bus.o_busy && !prev) found = 1;
            else if (bus.o_busy)     hi++;
            prev = bus.o_busy;
        end
    endtask

    // Arm one full frame of digit expectations and check its duration.
    task automatic display_frame();
        int cyc, hi;
        bit ok;
        logic [3:0] one;
        disp_t e;
        one = 4'b0001;
        wait_rise(cyc, hi, ok);
        check("frame_start_seen", 32'(ok), 32'd1);
        for (int k = 0; k < 16; k++) begin
            e.d   = model_buf[k][6:0];
            e.a   = 2'(3 - (k % 4));
            e.wrn = ~(one << (k / 4));
            exp_disp.push_back(e);
        end
        wait_rise(cyc, hi, ok);
        check("next_frame_seen", 32'(ok), 32'd1);
        check("frame_period", 32'(cyc), 32'(FRAME_CYC));
        check("busy_cycles", 32'(hi + 1), 32'(16 * CHAR_CYC + 1));
        check("digits_left", 32'(exp_disp.size()), 32'd0);
        exp_disp.delete();
    endtask

    task automatic monitor();
        int    since_re = 100;
        int    plen     = 0;
        bit    in_pulse = 0;
        bit    chk_len  = 0;
        int    ctog     = 0;
        int    ccnt     = 0;
        logic  cprev    = 1'b1;
        wr_t   w;
        disp_t e;
        forever begin
            @(negedge i_clk);
            if (i_reset) begin
                in_pulse = 0; chk_len = 0; since_re = 100;
                ctog = 0; ccnt = 0; cprev = 1'b1;
                continue;
            end
            check("we_re_overlap", 32'(bus.o_mem_we & bus.o_mem_re), 32'd0);
            check("ready_vs_fetch", 32'(bus.o_wr_ready), 32'(!bus.o_mem_re));

            if (bus.o_mem_we) begin
                if (exp_wr.size() == 0) check("write_unexpected", 32'(exp_wr.size()), 32'd1);
                else begin
                    w = exp_wr.pop_front();
                    check("mem_waddr", 32'(bus.o_mem_waddr), 32'(w.a));
                    check("mem_wdata", 32'(bus.o_mem_wdata), 32'(w.d));
                end
            end

            ccnt++;
            if (bus.o_caret_strobe !== cprev) begin
                if (ctog < 12) check("caret_period", 32'(ccnt), 32'(BLINK_DIV));
                ctog++;
                ccnt  = 0;
                cprev = bus.o_caret_strobe;
            end

            if (bus.o_mem_re) since_re = 0;
            else              since_re++;
            if (bus.o_hpdl_wr_n != 4'hF) begin
                if (!in_pulse) begin
                    in_pulse = 1; plen = 1; chk_len = 0;
                    if (exp_disp.size() > 0) begin
                        e = exp_disp.pop_front();
                        chk_len = 1;
                        check("hpdl_d", 32'(bus.o_hpdl_d), 32'(e.d));
                        check("hpdl_a", 32'(bus.o_hpdl_a), 32'(e.a));
                        check("hpdl_wr_n", 32'(bus.o_hpdl_wr_n), 32'(e.wrn));
                        check("setup_gap", 32'(since_re), 32'(SETUP_CYC + 2));
                    end
                end else plen++;
            end else if (in_pulse) begin
                in_pulse = 0;
                if (chk_len) check("pulse_width", 32'(plen), 32'(PULSE_CYC));
            end
        end
    endtask

    initial begin
        bit found;
        i_reset        = 1'b1;
        bus.i_wr_valid = 1'b0;
        bus.i_wr_data  = 8'h00;
        model_cur      = 0;
        for (int i = 0; i < 16; i++) model_buf[i] = 8'h20;
        fork monitor(); join_none

        repeat (3) @(negedge i_clk);
        check("rst_wr_n", 32'(bus.o_hpdl_wr_n), 32'hF);
        check("rst_d", 32'(bus.o_hpdl_d), 32'd0);
        check("rst_a", 32'(bus.o_hpdl_a), 32'd0);
        check("rst_we", 32'(bus.o_mem_we), 32'd0);
        check("rst_re", 32'(bus.o_mem_re), 32'd0);
        check("rst_raddr", 32'(bus.o_mem_raddr), 32'd0);
        check("rst_wdata", 32'(bus.o_mem_wdata), 32'd0);
        check("rst_waddr", 32'(bus.o_mem_waddr), 32'd0);
        check("rst_caret", 32'(bus.o_caret_strobe), 32'd1);
        check("rst_busy", 32'(bus.o_busy), 32'd0);
        #2 i_reset = 1'b0;
        @(negedge i_clk);

        // Lower-case conversion, then a dropped control char.
        send(8'h61); idle(3);
        check("waddr_after_a", 32'(bus.o_mem_waddr), 32'(model_cur));
        send(8'h07); idle(3);
        check("waddr_after_bel", 32'(bus.o_mem_waddr), 32'(model_cur));

        // Cursor saturation, CR and backspace at column 0.
        send(8'h0D);
        for (int i = 0; i < 17; i++) send(8'(8'h41 + i));
        idle(3);
        check("waddr_saturated", 32'(bus.o_mem_waddr), 32'd15);
        send(8'h0D); idle(3);
        check("waddr_after_cr", 32'(bus.o_mem_waddr), 32'd0);
        send(8'h08); idle(3);
        check("waddr_after_bs", 32'(bus.o_mem_waddr), 32'd0);

        // Random printable line, then one full scanned frame.
        for (int i = 0; i < 16; i++) send(8'($urandom_range(8'h20, 8'h7A)));
        idle(5);
        display_frame();

        // Back-to-back random chars with valid held high across scans.
        for (int i = 0; i < 300; i++) send(8'($urandom_range(0, 127)));
        idle(5);
        check("writes_drained", 32'(exp_wr.size()), 32'd0);
        display_frame();

        // Asynchronous reset in the middle of a write strobe.
        found = 0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge i_clk);
            if (bus.o_hpdl_wr_n != 4'hF) found = 1;
        end
        check("pulse_seen", 32'(found), 32'd1);
        #1 i_reset = 1'b1;
        #1 check("async_wr_n", 32'(bus.o_hpdl_wr_n), 32'hF);
        exp_wr.delete();
        exp_disp.delete();
        model_cur = 0;
        repeat (2) @(negedge i_clk);
        #2 i_reset = 1'b0;
        @(negedge i_clk);
        check("post_rst_busy", 32'(bus.o_busy), 32'd0);
        check("post_rst_waddr", 32'(bus.o_mem_waddr), 32'd0);
        check("post_rst_caret", 32'(bus.o_caret_strobe), 32'd1);

        for (int i = 0; i < 5; i++) send(8'($urandom_range(8'h20, 8'h7A)));
        idle(3);
        check("waddr_after_rst_writes", 32'(bus.o_mem_waddr), 32'(model_cur));
        display_frame();
        idle(20);
        check("final_writes_drained", 32'(exp_wr.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
